// File: rtl/halfband_decim_pkg.sv
// Shared constants and coefficient table for the half-band decimator.
package halfband_decim_pkg;

  localparam int HB_COEF_WIDTH = 18;
  localparam int CENTER_SHIFT  = 16;
  localparam int OUT_SHIFT     = 17;
  localparam int BUF_DEPTH     = 32;
  localparam int PTR_W         = 5;
  localparam int NUM_K         = 8;

  typedef logic signed [HB_COEF_WIDTH-1:0] coef_t;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } issue_state_e;

  // Symmetric non-zero outer taps C_k (Q1.17); h[2k] = h[30-2k] = C_k.
  // The values add up to 32768, so together with the 0.5 centre tap the DC gain is 1.
  function automatic coef_t hb_coef(input logic [2:0] k);
    case (k)
      3'd0:    return -18'sd60;
      3'd1:    return  18'sd180;
      3'd2:    return -18'sd420;
      3'd3:    return  18'sd850;
      3'd4:    return -18'sd1550;
      3'd5:    return  18'sd2700;
      3'd6:    return -18'sd4900;
      3'd7:    return  18'sd35968;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/halfband_mac.sv
// Pre-add / multiply / accumulate pipeline with first/last job tags,
// followed by half-up rounding and saturation to the output width.
module halfband_mac
  import halfband_decim_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = HB_COEF_WIDTH,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic                    i_first,
  input  logic                    i_last,
  input  logic [2:0]              i_k,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic signed [WIDTH-1:0] i_c,
  output logic                    o_strobe,
  output logic signed [WIDTH-1:0] o_dout
);

  localparam int PROD_W = WIDTH + 1 + COEF_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 << (WIDTH - 1)));
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1 << (OUT_SHIFT - 1));

  logic                           r_p_valid, r_p_first, r_p_last;
  logic signed [WIDTH:0]          r_p_sum;
  logic signed [COEF_WIDTH-1:0]   r_p_coef;
  logic signed [WIDTH-1:0]        r_p_center;

  logic                           r_m_valid, r_m_first, r_m_last;
  logic signed [PROD_W-1:0]       r_m_prod;
  logic signed [WIDTH-1:0]        r_m_center;

  logic                           r_acc_last;
  logic signed [ACC_WIDTH-1:0]    r_acc;

  logic signed [WIDTH:0]          w_pre;
  logic signed [ACC_WIDTH-1:0]    w_round;
  logic signed [ACC_WIDTH-1:0]    w_shift;
  logic signed [WIDTH-1:0]        w_sat;

  assign w_pre = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};

  // Symmetric pre-add of the mirrored tap pair plus coefficient lookup.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p_valid  <= 1'b0;
      r_p_first  <= 1'b0;
      r_p_last   <= 1'b0;
      r_p_sum    <= '0;
      r_p_coef   <= '0;
      r_p_center <= '0;
    end else begin
      r_p_valid  <= i_valid;
      r_p_first  <= i_valid & i_first;
      r_p_last   <= i_valid & i_last;
      r_p_sum    <= w_pre;
      r_p_coef   <= COEF_WIDTH'(hb_coef(i_k));
      r_p_center <= i_c;
    end
  end

  // Registered multiply of the pre-added pair by its coefficient.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m_valid  <= 1'b0;
      r_m_first  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_prod   <= '0;
      r_m_center <= '0;
    end else begin
      r_m_valid  <= r_p_valid;
      r_m_first  <= r_p_first;
      r_m_last   <= r_p_last;
      r_m_prod   <= r_p_sum * r_p_coef;
      r_m_center <= r_p_center;
    end
  end

  // Accumulate; the first product of a job restarts the sum and folds in
  // the 0.5 centre tap, so overlapping jobs never mix.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc      <= '0;
      r_acc_last <= 1'b0;
    end else begin
      r_acc_last <= r_m_valid & r_m_last;
      if (r_m_valid) begin
        if (r_m_first) begin
          r_acc <= ACC_WIDTH'(r_m_prod) + (ACC_WIDTH'(r_m_center) <<< CENTER_SHIFT);
        end else begin
          r_acc <= r_acc + ACC_WIDTH'(r_m_prod);
        end
      end
    end
  end

  // Half-up rounding and saturation of the finished accumulator.
  always_comb begin
    w_round = r_acc + RND_HALF;
    w_shift = w_round >>> OUT_SHIFT;
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[WIDTH-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[WIDTH-1:0];
    end else begin
      w_sat = w_shift[WIDTH-1:0];
    end
  end

  // Output register, updated once per completed job.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_strobe <= 1'b0;
      o_dout   <= '0;
    end else begin
      o_strobe <= r_acc_last;
      if (r_acc_last) begin
        o_dout <= w_sat;
      end
    end
  end

endmodule

// File: rtl/halfband_decim.sv
// Decimate-by-2 half-band FIR: circular sample buffer, trigger/issue engine
// and overrun flag around a single time-multiplexed MAC pipeline.
module halfband_decim
  import halfband_decim_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = HB_COEF_WIDTH,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    strobe_in,
  input  logic signed [WIDTH-1:0] din,
  output logic                    strobe_out,
  output logic signed [WIDTH-1:0] dout,
  output logic                    overrun
);

  logic signed [WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_base;
  logic                    r_phase;

  issue_state_e            r_state, w_state_next;
  logic [2:0]              r_k, w_k_next;

  logic                    w_trigger, w_busy_next, w_accept;
  logic [PTR_W-1:0]        w_addr_a, w_addr_b, w_addr_c;

  logic                    r_rd_valid, r_rd_first, r_rd_last;
  logic [2:0]              r_rd_k;
  logic signed [WIDTH-1:0] r_rd_a, r_rd_b, r_rd_c;

  assign w_trigger   = strobe_in & r_phase;
  // Busy only if the counter still has an issue slot left after this one;
  // a trigger landing on the last slot starts cleanly on the next cycle.
  assign w_busy_next = (r_state == ST_ISSUE) && (r_k != 3'd7);
  assign w_accept    = w_trigger & ~w_busy_next;

  assign w_addr_a = r_base - PTR_W'({r_k, 1'b0});
  assign w_addr_b = r_base - PTR_W'(30) + PTR_W'({r_k, 1'b0});
  assign w_addr_c = r_base - PTR_W'(15);

  // Circular input buffer, write pointer and decimation phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_wptr  <= '0;
      r_phase <= 1'b0;
    end else if (strobe_in) begin
      r_buf[r_wptr] <= din;
      r_wptr        <= r_wptr + 1'b1;
      r_phase       <= ~r_phase;
    end
  end

  // Issue engine state, coefficient counter and job base index.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      if (w_accept) begin
        r_base <= r_wptr;
      end
    end
  end

  // Next-state logic for the issue engine.
  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_ISSUE;
          w_k_next     = '0;
        end
      end
      ST_ISSUE: begin
        if (r_k == 3'd7) begin
          w_k_next     = '0;
          w_state_next = w_accept ? ST_ISSUE : ST_IDLE;
        end else begin
          w_k_next = r_k + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_k_next     = '0;
      end
    endcase
  end

  // Registered tap reads for the current issue slot, tagged first/last.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_first <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_k     <= '0;
      r_rd_a     <= '0;
      r_rd_b     <= '0;
      r_rd_c     <= '0;
    end else begin
      r_rd_valid <= (r_state == ST_ISSUE);
      r_rd_first <= (r_state == ST_ISSUE) && (r_k == 3'd0);
      r_rd_last  <= (r_state == ST_ISSUE) && (r_k == 3'd7);
      r_rd_k     <= r_k;
      r_rd_a     <= r_buf[w_addr_a];
      r_rd_b     <= r_buf[w_addr_b];
      r_rd_c     <= r_buf[w_addr_c];
    end
  end

  // Sticky flag for dropped triggers.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (w_trigger && !w_accept) begin
      overrun <= 1'b1;
    end
  end

  halfband_mac #(
    .WIDTH      (WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_valid  (r_rd_valid),
    .i_first  (r_rd_first),
    .i_last   (r_rd_last),
    .i_k      (r_rd_k),
    .i_a      (r_rd_a),
    .i_b      (r_rd_b),
    .i_c      (r_rd_c),
    .o_strobe (strobe_out),
    .o_dout   (dout)
  );

endmodule
